// File: rtl/two_reg_fifo_if.sv
//------------------------------------------------------------------------------
// Module  : two_reg_fifo_if
// Brief   : Write/read handshake bundle for the two-entry FWFT FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface two_reg_fifo_if #(
    parameter int WIDTH = 32
);
    logic             iWrEn;
    logic [WIDTH-1:0] iWrDat;
    logic             iRdEn;
    logic             oFul;
    logic             oEmpty;
    logic [1:0]       oDatVld;
    logic [WIDTH-1:0] oRdDat;

    // Producer/consumer side of the buffer
    modport master (
        output iWrEn,
        output iWrDat,
        output iRdEn,
        input  oFul,
        input  oEmpty,
        input  oDatVld,
        input  oRdDat
    );

    // The FIFO itself
    modport slave (
        input  iWrEn,
        input  iWrDat,
        input  iRdEn,
        output oFul,
        output oEmpty,
        output oDatVld,
        output oRdDat
    );
endinterface

`default_nettype wire

// File: rtl/two_reg_fifo.sv
//------------------------------------------------------------------------------
// Module  : two_reg_fifo
// Brief   : Two-entry first-word-fall-through FIFO (head R0, tail R1) with
//           per-entry valid bits; elastic buffer between ring-NoC stages.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module two_reg_fifo #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    two_reg_fifo_if.slave   bus
);

    localparam logic [1:0] c_VLD_EMPTY = 2'b00;
    localparam logic [1:0] c_VLD_ONE   = 2'b01;
    localparam logic [1:0] c_VLD_FULL  = 2'b11;

    logic [WIDTH-1:0] r_r0;
    logic [WIDTH-1:0] r_r1;
    logic [1:0]       r_vld;

    logic [WIDTH-1:0] w_r0_nxt;
    logic [WIDTH-1:0] w_r1_nxt;
    logic [1:0]       w_vld_nxt;
    logic             w_rd_acc;
    logic             w_wr_acc;

    // A write while full is only accepted when the head leaves in the same cycle
    assign w_rd_acc = bus.iRdEn & r_vld[0];
    assign w_wr_acc = bus.iWrEn & (~r_vld[1] | w_rd_acc);

    always_comb begin
        w_r0_nxt  = r_r0;
        w_r1_nxt  = r_r1;
        w_vld_nxt = r_vld;
        case (r_vld)
            c_VLD_EMPTY: begin
                if (w_wr_acc) begin
                    w_r0_nxt  = bus.iWrDat;
                    w_vld_nxt = c_VLD_ONE;
                end
            end
            c_VLD_ONE: begin
                case ({w_rd_acc, w_wr_acc})
                    2'b01: begin
                        w_r1_nxt  = bus.iWrDat;
                        w_vld_nxt = c_VLD_FULL;
                    end
                    2'b10: w_vld_nxt = c_VLD_EMPTY;
                    2'b11: w_r0_nxt  = bus.iWrDat;
                    default: ;
                endcase
            end
            c_VLD_FULL: begin
                // Tail compacts into the head so 2'b10 can never be reached
                if (w_rd_acc) begin
                    w_r0_nxt = r_r1;
                    if (w_wr_acc) begin
                        w_r1_nxt = bus.iWrDat;
                    end else begin
                        w_vld_nxt = c_VLD_ONE;
                    end
                end
            end
            default: w_vld_nxt = c_VLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r0  <= '0;
            r_r1  <= '0;
            r_vld <= c_VLD_EMPTY;
        end else begin
            r_r0  <= w_r0_nxt;
            r_r1  <= w_r1_nxt;
            r_vld <= w_vld_nxt;
        end
    end

    assign bus.oDatVld = r_vld;
    assign bus.oEmpty  = ~r_vld[0];
    assign bus.oFul    = r_vld[1];
    assign bus.oRdDat  = r_vld[0] ? r_r0 : '0;

endmodule

`default_nettype wire

// File: tb/tb_two_reg_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_two_reg_fifo
// Brief   : Directed self-checking bench for two_reg_fifo with a queue model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_two_reg_fifo;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    logic [WIDTH-1:0] q[$];

    two_reg_fifo_if #(.WIDTH(WIDTH)) bus ();

    two_reg_fifo #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        logic [1:0]       e_vld;
        logic [WIDTH-1:0] e_dat;
        e_vld = (q.size() == 0) ? 2'b00 : (q.size() == 1) ? 2'b01 : 2'b11;
        e_dat = (q.size() == 0) ? '0 : q[0];
        check({tag, ".vld"},   32'(bus.oDatVld), 32'(e_vld));
        check({tag, ".dat"},   32'(bus.oRdDat),  32'(e_dat));
        check({tag, ".ful"},   32'(bus.oFul),    32'(q.size() == 2));
        check({tag, ".empty"}, 32'(bus.oEmpty),  32'(q.size() == 0));
    endtask

    // One clock of stimulus; the scoreboard pops what a read should return
    task automatic step(input string tag, input logic wr, input logic [WIDTH-1:0] dat, input logic rd);
        logic rd_acc;
        logic wr_acc;
        logic [WIDTH-1:0] exp;
        bus.iWrEn  = wr;
        bus.iWrDat = dat;
        bus.iRdEn  = rd;
        #1;
        rd_acc = rd && (q.size() > 0);
        wr_acc = wr && ((q.size() < 2) || rd_acc);
        if (rd_acc) begin
            exp = q.pop_front();
            check({tag, ".pop"}, 32'(bus.oRdDat), 32'(exp));
        end
        if (wr_acc) q.push_back(dat);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst        = 1'b0;
        bus.iWrEn  = 1'b1;
        bus.iWrDat = 8'hAA;
        bus.iRdEn  = 1'b0;

        // Reset held with a pending write that must be ignored
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_state("reset");
        end
        @(negedge clk);
        rst       = 1'b1;
        bus.iWrEn = 1'b0;
        @(posedge clk);
        #1;
        check_state("post_reset");

        step("wr05", 1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 3; i++) step("hold05", 1'b0, 8'h00, 1'b0);
        step("drain05", 1'b0, 8'h00, 1'b1);

        step("wr01", 1'b1, 8'h01, 1'b0);
        step("wr02", 1'b1, 8'h02, 1'b0);
        step("wr03_drop", 1'b1, 8'h03, 1'b0);
        step("rd01", 1'b0, 8'h00, 1'b1);
        step("rd02", 1'b0, 8'h00, 1'b1);
        step("rd_empty", 1'b0, 8'h00, 1'b1);

        step("fill01", 1'b1, 8'h01, 1'b0);
        step("fill02", 1'b1, 8'h02, 1'b0);
        step("full_rw", 1'b1, 8'h03, 1'b1);
        step("rd_a", 1'b0, 8'h00, 1'b1);
        step("rd_b", 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 10; i++) step("stream", 1'b1, 8'(8'h10 + i), 1'b1);

        // Asynchronous reset mid-stream, away from any clock edge
        bus.iWrEn  = 1'b1;
        bus.iWrDat = 8'h40;
        bus.iRdEn  = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("first_after_rst", 1'b1, 8'h77, 1'b0);
        step("rd77", 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
